// File: rtl/simple_cpu_pkg.sv
// Shared definitions for the Simple CPU control slice.
//   state_t    : control sequencer states (4-bit encoding, exported as state_out)
//   OP_*       : 2-bit opcodes held in IR (instruction bits [N-1:N-2])
//   ALUSEL_*   : ALU function select values
package simple_cpu_pkg;

  typedef enum logic [3:0] {
    FETCH1 = 4'd0,
    FETCH2 = 4'd1,
    FETCH3 = 4'd2,
    ADD1   = 4'd3,
    ADD2   = 4'd4,
    AND1   = 4'd5,
    AND2   = 4'd6,
    JMP1   = 4'd7,
    INC1   = 4'd8
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  localparam logic ALUSEL_ADD = 1'b0;
  localparam logic ALUSEL_AND = 1'b1;

endpackage

// File: rtl/simple_cpu_ctrl_if.sv
// Memory bus between the Simple CPU controller and the memory model.
//   mem_rdata : N   read data, combinational from mem_addr (memory -> ctrl)
//   mem_addr  : AW  word address, always equal to AR  (ctrl -> memory)
//   mem_rd    : 1   read strobe                        (ctrl -> memory)
// Handshake: there is no ready/valid pair. The memory is combinational, so
// mem_rdata is valid in the same cycle that mem_rd=1 is presented with
// mem_addr; the controller captures it on the following rising clock edge.
interface simple_cpu_ctrl_if #(
  parameter int N  = 8,
  parameter int AW = 6
);
  logic [N-1:0]  mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;

  modport master (input mem_rdata, output mem_addr, output mem_rd);
  modport slave  (output mem_rdata, input mem_addr, input mem_rd);
endinterface

// File: rtl/simple_cpu_ctrl_alu.sv
// Simple CPU ALU: combinational ADD / AND of the accumulator and one operand.
//   ALUSEL : 1  0 = AC + AR (carry discarded), 1 = AC & AR
//   AC     : N  accumulator operand
//   AR     : N  second operand (the controller connects DR here)
//   q      : N  result
module simple_cpu_ctrl_alu
  import simple_cpu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         ALUSEL,
  input  logic [N-1:0] AC,
  input  logic [N-1:0] AR,
  output logic [N-1:0] q
);

  always_comb begin
    q = AC + AR;
    if (ALUSEL == ALUSEL_AND) q = AC & AR;
  end

endmodule

// File: rtl/simple_cpu_ctrl.sv
// Simple CPU control sequencer and register file (PC, AR, DR, IR, AC).
// Fetches 8-bit instructions over the memory bus, decodes them and either
// drives the ALU (ADD/AND), reloads the PC (JMP) or increments AC (INC).
//   clk, rst  : clock (rising edge), asynchronous active-high reset
//   en        : run enable, only looked at in FETCH1
//   bus       : memory bus (master side): mem_addr = AR, mem_rd, mem_rdata
//   ac_out    : accumulator
//   pc_out    : program counter
//   state_out : current sequencer state (debug)
module simple_cpu_ctrl
  import simple_cpu_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  simple_cpu_ctrl_if.master         bus,
  output logic [N-1:0]              ac_out,
  output logic [AW-1:0]             pc_out,
  output logic [3:0]                state_out
);

  state_t        state, state_nxt;
  logic [AW-1:0] pc, ar;
  logic [N-1:0]  dr, ac;
  logic [1:0]    ir;
  logic [N-1:0]  alu_q;

  // Register-transfer controls decoded from the current state.
  logic ld_ar_pc;    // AR <= PC
  logic ld_dr_mem;   // DR <= mem_rdata
  logic inc_pc;      // PC <= PC + 1
  logic ld_ir_ar;    // IR <= opcode, AR <= address field
  logic ld_ac_alu;   // AC <= ALU result
  logic ld_pc_dr;    // PC <= address field (JMP)
  logic inc_ac;      // AC <= AC + 1
  logic mem_rd;
  logic alusel;

  simple_cpu_ctrl_alu #(.N(N)) u_alu (
    .ALUSEL (alusel),
    .AC     (ac),
    .AR     (dr),
    .q      (alu_q)
  );

  always_comb begin
    state_nxt = FETCH1;
    ld_ar_pc  = 1'b0;
    ld_dr_mem = 1'b0;
    inc_pc    = 1'b0;
    ld_ir_ar  = 1'b0;
    ld_ac_alu = 1'b0;
    ld_pc_dr  = 1'b0;
    inc_ac    = 1'b0;
    mem_rd    = 1'b0;
    alusel    = ALUSEL_ADD;
    unique case (state)
      FETCH1: begin
        if (en) begin
          ld_ar_pc  = 1'b1;
          state_nxt = FETCH2;
        end else begin
          state_nxt = FETCH1;
        end
      end
      FETCH2: begin
        ld_dr_mem = 1'b1;
        inc_pc    = 1'b1;
        mem_rd    = 1'b1;
        state_nxt = FETCH3;
      end
      FETCH3: begin
        ld_ir_ar = 1'b1;
        // IR is loaded on this same edge, so dispatch on DR's opcode bits.
        unique case (dr[N-1:N-2])
          OP_ADD:  state_nxt = ADD1;
          OP_AND:  state_nxt = AND1;
          OP_JMP:  state_nxt = JMP1;
          default: state_nxt = INC1;
        endcase
      end
      ADD1: begin
        ld_dr_mem = 1'b1;
        mem_rd    = 1'b1;
        state_nxt = ADD2;
      end
      ADD2: begin
        ld_ac_alu = 1'b1;
      end
      AND1: begin
        ld_dr_mem = 1'b1;
        mem_rd    = 1'b1;
        state_nxt = AND2;
      end
      AND2: begin
        ld_ac_alu = 1'b1;
        // IR holds OP_AND here; selecting from it keeps the ALU function
        // tied to the decoded instruction rather than to the state alone.
        alusel    = (ir == OP_AND) ? ALUSEL_AND : ALUSEL_ADD;
      end
      JMP1: begin
        ld_pc_dr = 1'b1;
      end
      INC1: begin
        inc_ac = 1'b1;
      end
      default: begin
        // Unused encodings fall back to FETCH1 with no register transfer.
        state_nxt = FETCH1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH1;
      pc    <= '0;
      ar    <= '0;
      dr    <= '0;
      ir    <= '0;
      ac    <= '0;
    end else begin
      state <= state_nxt;
      if (ld_ar_pc)  ar <= pc;
      if (ld_dr_mem) dr <= bus.mem_rdata;
      if (inc_pc)    pc <= pc + 1'b1;
      if (ld_ir_ar) begin
        ir <= dr[N-1:N-2];
        ar <= dr[AW-1:0];
      end
      if (ld_pc_dr)  pc <= dr[AW-1:0];
      if (ld_ac_alu) ac <= alu_q;
      if (inc_ac)    ac <= ac + 1'b1;
    end
  end

  assign bus.mem_addr = ar;
  assign bus.mem_rd   = mem_rd;
  assign ac_out       = ac;
  assign pc_out       = pc;
  assign state_out    = state;

endmodule
